// File: rtl/pe_sched_pkg.sv
// Shared types and defaults for the PE row scheduler.
// State encoding, widths and MAC pipeline latency.
package pe_sched_pkg;

  localparam int ADDR_W_D = 4;
  localparam int CNT_W_D  = 8;
  localparam int STR_W_D  = 3;
  localparam int PIPE_LAT = 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4,
    S_SHIFT = 3'd5,
    S_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/pe_sched_if.sv
// PE-side bundle: buffer status in, spad/MAC/psum control out.
// master = scheduler, slave = PE datapath and buffer controllers.
interface pe_sched_if #(
  parameter int ADDR_W = 4,
  parameter int STR_W  = 3
);
  logic              filt_ready;
  logic [ADDR_W:0]   if_count;
  logic              psum_ready;
  logic [ADDR_W-1:0] filt_addr;
  logic [ADDR_W-1:0] if_addr;
  logic              mac_en;
  logic              acc_clr;
  logic              psum_valid;
  logic              if_pop;
  logic [STR_W-1:0]  if_pop_cnt;

  modport master (
    input  filt_ready, if_count, psum_ready,
    output filt_addr, if_addr, mac_en, acc_clr,
    output psum_valid, if_pop, if_pop_cnt
  );

  modport slave (
    output filt_ready, if_count, psum_ready,
    input  filt_addr, if_addr, mac_en, acc_clr,
    input  psum_valid, if_pop, if_pop_cnt
  );
endinterface

// File: rtl/pe_row_scheduler.sv
// Sequences one PE through a 1-D row convolution:
// tap stepping, accumulator clear, psum handshake and ifmap pops.
module pe_row_scheduler
  import pe_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int CNT_W  = CNT_W_D,
  parameter int STR_W  = STR_W_D
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] filt_len,
  input  logic [STR_W-1:0]  stride,
  input  logic [CNT_W-1:0]  num_out,
  pe_sched_if.master        pe,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t state, nxt;

  logic [ADDR_W-1:0] k;
  logic [CNT_W-1:0]  out_cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [ADDR_W-1:0] len_q;
  logic [STR_W-1:0]  str_q;
  logic [CNT_W-1:0]  num_q;
  logic              bad_q;
  logic              mac_en;
  logic              acc_clr;
  logic              psum_valid;
  logic              if_pop;
  logic              data_ok;

  assign cnt_inc = out_cnt + CNT_W'(1);
  assign data_ok = pe.filt_ready &&
                   (pe.if_count >= {1'b0, len_q});

  // Legality is judged on the latched config in WAIT,
  // so a bad start still spends one busy cycle.
  always_comb begin
    nxt        = state;
    mac_en     = 1'b0;
    acc_clr    = 1'b0;
    psum_valid = 1'b0;
    if_pop     = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    busy       = (state != S_IDLE);
    unique case (state)
      S_IDLE: begin
        if (start) nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bad_q)        nxt = S_DONE;
        else if (data_ok) nxt = S_MAC;
      end
      S_MAC: begin
        mac_en  = 1'b1;
        acc_clr = (k == '0);
        if (k == len_q - ADDR_W'(1)) nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (k == ADDR_W'(PIPE_LAT - 1)) nxt = S_OUT;
      end
      S_OUT: begin
        psum_valid = 1'b1;
        if (pe.psum_ready)
          nxt = (cnt_inc == num_q) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        if_pop = 1'b1;
        nxt    = S_WAIT;
      end
      S_DONE: begin
        done = 1'b1;
        err  = bad_q;
        nxt  = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      k       <= '0;
      out_cnt <= '0;
      len_q   <= '0;
      str_q   <= '0;
      num_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && start) begin
        len_q   <= filt_len;
        str_q   <= stride;
        num_q   <= num_out;
        bad_q   <= (filt_len == '0) || (stride == '0) ||
                   (num_out == '0);
        out_cnt <= '0;
      end
      // k doubles as the drain-latency counter
      if ((state == S_MAC || state == S_DRAIN) && nxt == state)
        k <= k + ADDR_W'(1);
      else
        k <= '0;
      if (state == S_OUT && pe.psum_ready)
        out_cnt <= cnt_inc;
    end
  end

  assign pe.mac_en     = mac_en;
  assign pe.acc_clr    = acc_clr;
  assign pe.filt_addr  = mac_en ? k : '0;
  assign pe.if_addr    = mac_en ? k : '0;
  assign pe.psum_valid = psum_valid;
  assign pe.if_pop     = if_pop;
  assign pe.if_pop_cnt = if_pop ? str_q : '0;

endmodule

// File: tb/tb_pe_row_scheduler.sv
// Scoreboard bench for pe_row_scheduler: directed rows, expected
// events queued per row and matched by a negedge monitor.
module tb_pe_row_scheduler;

  localparam int K_MAC  = 0;
  localparam int K_PSUM = 1;
  localparam int K_POP  = 2;
  localparam int K_DONE = 3;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic [3:0] filt_len = '0;
  logic [2:0] stride = '0;
  logic [7:0] num_out = '0;
  logic       busy, done, err;

  pe_sched_if #(.ADDR_W(4), .STR_W(3)) pif ();

  pe_row_scheduler #(.ADDR_W(4), .CNT_W(8), .STR_W(3)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .filt_len (filt_len),
    .stride   (stride),
    .num_out  (num_out),
    .pe       (pif),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   t0 = 0;
  int   tests = 0;
  int   fails = 0;
  int   vcnt = 0;
  ev_t  exq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic exp_ev(int kind, int c, int v);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    exq.push_back(e);
  endtask

  function automatic int macv(int k, int clr);
    return (clr << 8) | (k << 4) | k;
  endfunction

  task automatic see(int kind, int v);
    ev_t e;
    if (exq.size() == 0) begin
      chk("unexpected_event_kind", kind, -1);
      return;
    end
    e = exq.pop_front();
    chk("ev_kind", kind, e.kind);
    chk("ev_cycle", cyc - t0, e.cyc);
    chk("ev_value", v, e.val);
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (pif.psum_valid) vcnt++;
      if (pif.acc_clr && !pif.mac_en)
        chk("acc_clr_without_mac", 1, 0);
      if (err && !done) chk("err_without_done", 1, 0);
      if (pif.mac_en)
        see(K_MAC, {23'd0, pif.acc_clr, pif.if_addr,
                    pif.filt_addr});
      if (pif.psum_valid && pif.psum_ready) see(K_PSUM, 0);
      if (pif.if_pop) see(K_POP, int'(pif.if_pop_cnt));
      if (done) see(K_DONE, int'(err));
    end
  end

  task automatic start_row(int l, int s, int n);
    @(posedge clk);
    #1;
    filt_len = 4'(l);
    stride   = 3'(s);
    num_out  = 8'(n);
    start    = 1'b1;
    t0       = cyc;
    @(posedge clk);
    #1;
    start    = 1'b0;
  endtask

  task automatic drain(string name);
    int i;
    for (i = 0; i < 200 && exq.size() != 0; i++)
      @(posedge clk);
    chk(name, exq.size(), 0);
    exq.delete();
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_idle"}, int'(busy), 0);
  endtask

  task automatic push_basic();
    exp_ev(K_MAC, 2, macv(0, 1));
    exp_ev(K_MAC, 3, macv(1, 0));
    exp_ev(K_MAC, 4, macv(2, 0));
    exp_ev(K_PSUM, 6, 0);
    exp_ev(K_POP, 7, 1);
    exp_ev(K_MAC, 9, macv(0, 1));
    exp_ev(K_MAC, 10, macv(1, 0));
    exp_ev(K_MAC, 11, macv(2, 0));
    exp_ev(K_PSUM, 13, 0);
    exp_ev(K_DONE, 14, 0);
  endtask

  initial begin
    pif.filt_ready = 1'b1;
    pif.if_count   = 5'd8;
    pif.psum_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_mac_en", int'(pif.mac_en), 0);
    chk("rst_psum_valid", int'(pif.psum_valid), 0);
    chk("rst_if_pop", int'(pif.if_pop), 0);
    rstn = 1'b1;

    // basic row
    push_basic();
    start_row(3, 1, 2);
    chk("basic_busy_wait", int'(busy), 1);
    drain("basic");

    // backpressure: ready low for cycles 5..9
    pif.psum_ready = 1'b0;
    vcnt = 0;
    exp_ev(K_MAC, 2, macv(0, 1));
    exp_ev(K_MAC, 3, macv(1, 0));
    exp_ev(K_PSUM, 10, 0);
    exp_ev(K_POP, 11, 1);
    exp_ev(K_MAC, 13, macv(0, 1));
    exp_ev(K_MAC, 14, macv(1, 0));
    exp_ev(K_PSUM, 16, 0);
    exp_ev(K_DONE, 17, 0);
    start_row(2, 1, 2);
    repeat (9) @(posedge clk);
    #1;
    chk("bp_valid_held", int'(pif.psum_valid), 1);
    pif.psum_ready = 1'b1;
    drain("backpressure");
    chk("bp_valid_cycles", vcnt, 7);

    // starvation: if_count 2 < filt_len 3 until cycle 10
    pif.if_count = 5'd2;
    exp_ev(K_MAC, 11, macv(0, 1));
    exp_ev(K_MAC, 12, macv(1, 0));
    exp_ev(K_MAC, 13, macv(2, 0));
    exp_ev(K_PSUM, 15, 0);
    exp_ev(K_DONE, 16, 0);
    start_row(3, 1, 1);
    repeat (9) @(posedge clk);
    #1;
    chk("starve_busy", int'(busy), 1);
    pif.if_count = 5'd3;
    drain("starvation");

    // stride larger than filter length
    pif.if_count = 5'd2;
    exp_ev(K_MAC, 2, macv(0, 1));
    exp_ev(K_MAC, 3, macv(1, 0));
    exp_ev(K_PSUM, 5, 0);
    exp_ev(K_POP, 6, 4);
    exp_ev(K_MAC, 8, macv(0, 1));
    exp_ev(K_MAC, 9, macv(1, 0));
    exp_ev(K_PSUM, 11, 0);
    exp_ev(K_POP, 12, 4);
    exp_ev(K_MAC, 14, macv(0, 1));
    exp_ev(K_MAC, 15, macv(1, 0));
    exp_ev(K_PSUM, 17, 0);
    exp_ev(K_DONE, 18, 0);
    start_row(2, 4, 3);
    drain("stride_gt_len");
    pif.if_count = 5'd8;

    // illegal configurations
    exp_ev(K_DONE, 2, 1);
    start_row(3, 1, 0);
    drain("illegal_num_out");
    exp_ev(K_DONE, 2, 1);
    start_row(0, 1, 2);
    drain("illegal_filt_len");
    exp_ev(K_DONE, 2, 1);
    start_row(3, 0, 2);
    drain("illegal_stride");

    // reset mid-row at k=1, then a clean row
    exp_ev(K_MAC, 2, macv(0, 1));
    start_row(3, 1, 2);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_k1_addr", int'(pif.filt_addr), 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_mac_en", int'(pif.mac_en), 0);
    chk("mid_rst_addr", int'(pif.filt_addr), 0);
    chk("mid_rst_pop", int'(pif.if_pop), 0);
    chk("mid_rst_q", exq.size(), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    push_basic();
    start_row(3, 1, 2);
    drain("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
